imem_loader: RTL
================

# imem_loader

Writable 64-word instruction memory with a byte-stream loader. A host pushes a program one byte at a time over a valid/ready handshake. The block packs each four bytes into a 32-bit word and writes it into internal RAM. The processor fetch path reads the RAM through a combinational port with the same shape as the instruction ROM (6-bit word address, N-bit word), so a program can be loaded at run time instead of being fixed at synthesis.

## Interface
Parameters:
- N, 32, instruction word width; must be 32 (four bytes per word).
- AW, 6, word-address width; depth is 2**AW = 64 words.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin a load; sampled only in IDLE.
- word_count  in  AW+1  number of words to load, latched with start; legal range 1..64.
- byte_in  in  8  stream data.
- byte_valid  in  1  byte_in is valid.
- byte_ready  out  1  block accepts a byte this cycle.
- busy  out  1  a load is in progress (RECV or WRITE).
- cpu_hold  out  1  equals busy; holds the processor while a load is in progress.
- done  out  1  last load completed; held until the next accepted start.
- err  out  1  one-cycle pulse when start is rejected.
- addr  in  AW  fetch word address.
- q  out  N  combinational fetch data, mem[addr].

## Operation
- Storage: 64 x N array, write-only from the loader and read-only from the fetch port. Contents are not cleared by reset and are zero at power-up (initial value).
- FSM states: IDLE, RECV, WRITE.
- IDLE: byte_ready=0. Action on start=1 depends on word_count:
  - word_count in 1..64: latch count; clear wr_addr, byte_idx and done; go to RECV.
  - word_count = 0 or > 64: pulse err for one cycle and stay in IDLE; done is unchanged.
- RECV: byte_ready=1.
  - Each accepted byte (byte_valid & byte_ready) goes into word-buffer slot byte_idx, little-endian: the first byte fills [7:0] and the fourth fills [31:24].
  - byte_idx increments; on the 4th accept, byte_idx wraps to 0 and the FSM goes to WRITE.
- WRITE: byte_ready=0. The buffer is written to mem[wr_addr] on the edge that leaves this state, and wr_addr increments.
  - If the words written now equal count: set done and go to IDLE.
  - Otherwise return to RECV.
- start in RECV or WRITE is ignored and does not pulse err.
- wr_addr is AW bits. A 64-word load ends with wr_addr wrapped to 0; no write ever occurs past word 63.
- Reset asserted mid-load:
  - Aborts immediately and returns to IDLE; outputs go to reset values.
  - Fully written words are kept; a partially assembled word is discarded.
- Fetch during a load is allowed. q reflects the stored contents, not the buffer.

## Timing
- Reset values: byte_ready=0, busy=0, cpu_hold=0, done=0, err=0, FSM=IDLE, wr_addr=0, byte_idx=0.
- start is sampled at edge T; busy=1 and byte_ready=1 from T+1.
- Bytes are accepted one per cycle at most. A word needs at least 5 cycles: 4 RECV accepts plus 1 WRITE cycle. byte_valid gaps stretch RECV with no loss.
- The word is visible on q (when addr matches) immediately after the WRITE exit edge. In the WRITE cycle itself, q still shows the old value.
- After the final WRITE edge: busy=0 and done=1 in the same cycle. Minimum total load time is 5*count cycles after the start edge.
- err is high for exactly the cycle after the rejecting edge.
- q is purely combinational from addr and array contents, with zero-cycle latency.
- byte_ready does not depend combinationally on byte_valid.

## Test plan
- Reset: assert reset (low) mid-cycle -> all outputs 0 asynchronously; q at addr 0 = 32'h0 after power-up.
- Single word: start, word_count=1, bytes 01,00,00,F8 back-to-back -> busy for 5 cycles, then done=1; addr=0 gives q=32'hF8000001.
- Throttled stream: word_count=2 with byte_valid toggling every other cycle, bytes 02,80,00,F8,03,02,00,F8 -> mem[0]=32'hF8008002, mem[1]=32'hF8000203; byte_ready=0 in each WRITE cycle.
- Full depth: word_count=64, word k = 32'hA5000000+k -> mem[63]=32'hA500003F and mem[0]=32'hA5000000 (not overwritten after wrap); done=1.
- Illegal starts: word_count=0, then word_count=65 -> err pulses once each and busy stays 0. start during busy -> ignored, no err.
- Reset mid-load: word_count=3, reset after 1 full word plus 2 bytes -> IDLE; mem[0] updated, mem[1] unchanged. A new load of 1 word then writes mem[0] correctly.

Source files
------------

// File: rtl/imem_loader_if.sv
// Host/fetch-side bundle of the instruction-memory loader: byte stream handshake,
// load control/status, and the combinational fetch port.
interface imem_loader_if #(
  parameter int N  = 32,
  parameter int AW = 6
);
  logic          start;
  logic [AW:0]   word_count;
  logic [7:0]    byte_in;
  logic          byte_valid;
  logic          byte_ready;
  logic          busy;
  logic          cpu_hold;
  logic          done;
  logic          err;
  logic [AW-1:0] addr;
  logic [N-1:0]  q;

  modport master (
    output start, word_count, byte_in, byte_valid, addr,
    input  byte_ready, busy, cpu_hold, done, err, q
  );

  modport slave (
    input  start, word_count, byte_in, byte_valid, addr,
    output byte_ready, busy, cpu_hold, done, err, q
  );
endinterface

// File: rtl/imem_loader.sv
// Run-time writable instruction memory: packs a little-endian byte stream into
// 32-bit words and exposes them on a ROM-shaped combinational fetch port.
module imem_loader #(
  parameter int N  = 32,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          reset,
  imem_loader_if.slave  bus
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] DEPTH_W = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] ONE_W   = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  state_t        state_r;
  logic [AW:0]   count_r;
  logic [AW:0]   words_r;
  logic [AW-1:0] wr_addr_r;
  logic [1:0]    byte_idx_r;
  logic [N-1:0]  buf_r;
  logic          byte_ready_r;
  logic          busy_r;
  logic          done_r;
  logic          err_r;

  logic [AW:0]   words_next_s;
  logic          count_ok_s;

  // Power-up contents are zero; reset deliberately leaves the array alone.
  logic [N-1:0]  mem_r [DEPTH] = '{default: '0};

  assign words_next_s = words_r + ONE_W;
  assign count_ok_s   = (bus.word_count != {(AW+1){1'b0}}) && (bus.word_count <= DEPTH_W);

  // Load sequencer: accepts start, assembles bytes, and schedules word writes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      count_r      <= '0;
      words_r      <= '0;
      wr_addr_r    <= '0;
      byte_idx_r   <= 2'd0;
      buf_r        <= '0;
      byte_ready_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      err_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            if (count_ok_s) begin
              count_r      <= bus.word_count;
              words_r      <= '0;
              wr_addr_r    <= '0;
              byte_idx_r   <= 2'd0;
              done_r       <= 1'b0;
              busy_r       <= 1'b1;
              byte_ready_r <= 1'b1;
              state_r      <= ST_RECV;
            end else begin
              err_r <= 1'b1;
            end
          end
        end
        ST_RECV: begin
          if (bus.byte_valid && byte_ready_r) begin
            buf_r[{byte_idx_r, 3'b000} +: 8] <= bus.byte_in;
            byte_idx_r <= byte_idx_r + 2'd1;
            if (byte_idx_r == 2'd3) begin
              byte_ready_r <= 1'b0;
              state_r      <= ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          // wr_addr wraps to 0 after word 63; the word counter decides termination.
          wr_addr_r <= wr_addr_r + {{(AW-1){1'b0}}, 1'b1};
          words_r   <= words_next_s;
          if (words_next_s == count_r) begin
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            byte_ready_r <= 1'b1;
            state_r      <= ST_RECV;
          end
        end
        default: begin
          byte_ready_r <= 1'b0;
          busy_r       <= 1'b0;
          state_r      <= ST_IDLE;
        end
      endcase
    end
  end

  // Word store: commits the assembled buffer on the edge leaving WRITE.
  always_ff @(posedge clk) begin
    if (state_r == ST_WRITE) begin
      mem_r[wr_addr_r] <= buf_r;
    end
  end

  assign bus.byte_ready = byte_ready_r;
  assign bus.busy       = busy_r;
  assign bus.cpu_hold   = busy_r;
  assign bus.done       = done_r;
  assign bus.err        = err_r;
  assign bus.q          = mem_r[bus.addr];

endmodule
